// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and default sizing for the dual-clock FIFO pointer logic.
package gray_pkg;

    localparam int unsigned AWID_DEF = 4;
    localparam int unsigned DEPTH    = 1 << AWID_DEF;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB; bits at or above w are forced to zero.
    function automatic logic [31:0] gray2bin_f(input logic [31:0] g, input int unsigned w);
        logic [31:0] b;
        b     = '0;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        for (int i = 0; i < 32; i++) begin
            if (i >= int'(w)) begin
                b[i] = 1'b0;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin_comb.sv
// Purely combinational Gray-to-binary converter of parameterised width.
module gray_to_bin_comb
    import gray_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = W'(gray2bin_f(32'(gray), W));
    end

endmodule

// File: rtl/gray_wptr.sv
// Write-side pointer manager of a dual-clock FIFO: binary/Gray write pointer,
// full flag, pessimistic fill level and overflow pulse, all in the write domain.
module gray_wptr
    import gray_pkg::*;
#(
    parameter int unsigned AWID = AWID_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [AWID:0]   i_rptr_gray,
    output logic [AWID-1:0] o_waddr,
    output logic            o_wen,
    output logic [AWID:0]   o_wptr_gray,
    output logic            o_full,
    output logic [AWID:0]   o_level,
    output logic            o_overflow
);

    localparam int unsigned PW = AWID + 1;

    logic [AWID:0] wbin;
    logic [AWID:0] wbin_nxt;
    logic [AWID:0] gray_nxt;
    logic [AWID:0] rbin;
    logic [AWID:0] full_cmp;
    logic [AWID:0] level_nxt;
    logic          acc;

    gray_to_bin_comb #(.W(PW)) u_rptr_g2b (
        .gray (i_rptr_gray),
        .bin  (rbin)
    );

    assign acc     = i_push & ~o_full;
    assign o_wen   = acc;
    assign o_waddr = wbin[AWID-1:0];

    // Next pointer wraps naturally at 2**(AWID+1); full when write is one lap ahead of read.
    always_comb begin
        wbin_nxt  = wbin + PW'(acc);
        gray_nxt  = PW'(bin2gray(32'(wbin_nxt)));
        full_cmp  = {~i_rptr_gray[AWID:AWID-1], i_rptr_gray[AWID-2:0]};
        level_nxt = wbin_nxt - rbin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin        <= '0;
            o_wptr_gray <= '0;
            o_full      <= 1'b0;
            o_level     <= '0;
            o_overflow  <= 1'b0;
        end else begin
            wbin        <= wbin_nxt;
            o_wptr_gray <= gray_nxt;
            o_full      <= (gray_nxt == full_cmp);
            o_level     <= level_nxt;
            o_overflow  <= i_push & o_full;
        end
    end

endmodule

// File: tb/tb_gray_wptr.sv
// Directed self-checking bench for gray_wptr with AWID=4 (depth 16, 5-bit pointers).
module tb_gray_wptr;

    logic       clk;
    logic       rst;
    logic       push;
    logic [4:0] rptr_gray;
    logic [3:0] waddr;
    logic       wen;
    logic [4:0] wptr_gray;
    logic       full;
    logic [4:0] level;
    logic       overflow;

    int vectors;
    int miscompares;

    gray_wptr #(.AWID(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_push      (push),
        .i_rptr_gray (rptr_gray),
        .o_waddr     (waddr),
        .o_wen       (wen),
        .o_wptr_gray (wptr_gray),
        .o_full      (full),
        .o_level     (level),
        .o_overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] old_g;
        logic [4:0] m;
        logic [4:0] rb;
        vectors     = 0;
        miscompares = 0;

        // 1: reset with push held
        rst       = 1'b1;
        push      = 1'b1;
        rptr_gray = 5'd0;
        #2;
        check("rst_gray",     32'(wptr_gray), 32'h0);
        check("rst_level",    32'(level),     32'h0);
        check("rst_full",     32'(full),      32'h0);
        check("rst_overflow", 32'(overflow),  32'h0);
        check("rst_waddr",    32'(waddr),     32'h0);
        #10 rst = 1'b0;
        tick();
        check("first_gray",  32'(wptr_gray), 32'h01);
        check("first_level", 32'(level),     32'h1);
        check("first_waddr", 32'(waddr),     32'h1);

        // 2: fill to 16 entries with read pointer at 0
        for (int n = 2; n <= 16; n++) begin
            tick();
            check("fill_level", 32'(level), 32'(n));
            check("fill_full",  32'(full),  32'(n == 16));
        end
        check("full_gray", 32'(wptr_gray), 32'b11000);
        check("full_ovf",  32'(overflow),  32'h0);

        // 3: pushes while full are dropped
        check("full_wen", 32'(wen), 32'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("ovf_pulse", 32'(overflow),  32'h1);
            check("ovf_gray",  32'(wptr_gray), 32'b11000);
            check("ovf_level", 32'(level),     32'd16);
            check("ovf_wen",   32'(wen),       32'h0);
        end
        push = 1'b0;
        tick();
        check("ovf_clear", 32'(overflow), 32'h0);

        // 4: one read frees a slot; then simultaneous push and read
        rptr_gray = 5'b00001;
        tick();
        check("read_full",  32'(full),  32'h0);
        check("read_level", 32'(level), 32'd15);
        push      = 1'b1;
        rptr_gray = 5'b00011;
        #1;
        check("both_wen", 32'(wen), 32'h1);
        tick();
        check("both_level", 32'(level),     32'd15);
        check("both_gray",  32'(wptr_gray), 32'b11001);
        check("both_full",  32'(full),      32'h0);

        // 5: free-running push with read pointer trailing by 4, across the wrap
        push      = 1'b0;
        rptr_gray = 5'd0;
        rst       = 1'b1;
        #1;
        check("rst2_gray", 32'(wptr_gray), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m   = 5'd0;
        for (int t = 0; t < 40; t++) begin
            rb        = (t >= 4) ? 5'(t - 4) : 5'd0;
            rptr_gray = g(rb);
            push      = 1'b1;
            old_g     = wptr_gray;
            tick();
            m = m + 5'd1;
            check("run_gray",  32'(wptr_gray), 32'(g(m)));
            check("run_1bit",  32'($countones(old_g ^ wptr_gray)), 32'h1);
            check("run_full",  32'(full),  32'h0);
            check("run_level", 32'(level), (t >= 4) ? 32'd5 : 32'(t + 1));
            if (m == 5'd0) begin
                check("wrap_old", 32'(old_g),     32'b10000);
                check("wrap_new", 32'(wptr_gray), 32'b00000);
            end
        end

        // 6: asynchronous reset mid-burst
        push      = 1'b0;
        rptr_gray = 5'd0;
        rst       = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        push = 1'b1;
        for (int n = 0; n < 9; n++) tick();
        check("mid_level", 32'(level), 32'd9);
        #2 rst = 1'b1;
        #1;
        check("async_gray",  32'(wptr_gray), 32'h0);
        check("async_level", 32'(level),     32'h0);
        check("async_full",  32'(full),      32'h0);
        check("async_ovf",   32'(overflow),  32'h0);
        check("async_waddr", 32'(waddr),     32'h0);
        #3 rst = 1'b0;
        tick();
        check("restart_gray",  32'(wptr_gray), 32'h01);
        check("restart_level", 32'(level),     32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
